// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared defaults and FSM state encoding for mem_seq_master
package mem_seq_pkg;

  // Default geometry of the word RAM port
  localparam int AW_DEF   = 10;
  localparam int DW_DEF   = 16;
  localparam int LENW_DEF = 4;

  // FSM state encoding; ST_VERIFY is only reachable with MEM_SEQ_WRITE_VERIFY_EN
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WRITE  = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_VERIFY = 3'd4;

endpackage

// File: rtl/mem_seq_beat_ctr.sv
// rtl/mem_seq_beat_ctr.sv - RAM address register with wrap, beat down-counter and read-issue history
module mem_seq_beat_ctr
  import mem_seq_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [AW-1:0]   load_addr,
  input  logic [LENW-1:0] load_len,
  input  logic            advance,
  input  logic            issue_in,
  output logic [AW-1:0]   addr,
  output logic            last,
  output logic [1:0]      issue_sr
);

  logic [LENW-1:0] beats_left;

  // The final beat has been issued once no beats remain
  assign last = (beats_left == '0);

  // Address/beat counters; issue_sr tracks which cycles carried a burst read so
  // the capture stage knows when RAM data for an issued address is present
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      beats_left <= '0;
      issue_sr   <= 2'b00;
    end else begin
      issue_sr <= {issue_sr[0], issue_in};
      if (load) begin
        addr       <= load_addr;
        beats_left <= load_len;
      end else if (advance) begin
        addr       <= (addr == {AW{1'b1}}) ? '0 : addr + AW'(1);
        beats_left <= beats_left - LENW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_seq_master.sv
// rtl/mem_seq_master.sv - RAM-port initiator: single writes and incrementing read bursts (option: MEM_SEQ_WRITE_VERIFY_EN)
module mem_seq_master
  import mem_seq_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [LENW-1:0] req_len,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            wr_done,
  output logic            wr_err,
  output logic            busy,
  output logic            MemRead,
  output logic            MemWrite,
  output logic [AW-1:0]   Address,
  output logic [DW-1:0]   WriteData,
  input  logic [DW-1:0]   MemData
);

  logic [2:0] state;
  logic       accept;
  logic       advance;
  logic       issue_in;
  logic       last;
  logic [1:0] issue_sr;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
  logic       verify_wait;
`endif

  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_ready & req_valid;
  assign advance   = (state == ST_READ) & ~last;
  // Only burst reads feed the capture pipe; a verify read must not emit rsp_valid
  assign issue_in  = MemRead & (state == ST_READ);
  // Stage 2 of the issue history marks the cycle whose captured word is valid
  assign rsp_valid = issue_sr[1];

  mem_seq_beat_ctr #(
    .AW   (AW),
    .LENW (LENW)
  ) u_beat_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_addr (req_addr),
    .load_len  (req_len),
    .advance   (advance),
    .issue_in  (issue_in),
    .addr      (Address),
    .last      (last),
    .issue_sr  (issue_sr)
  );

  // Capture the RAM word when an issued address reaches the capture stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data <= '0;
    end else if (issue_sr[0]) begin
      rsp_data <= MemData;
    end
  end

`ifndef MEM_SEQ_WRITE_VERIFY_EN
  assign wr_err = 1'b0;
`endif

  // Control FSM and registered RAM strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      WriteData <= '0;
      wr_done   <= 1'b0;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
      wr_err      <= 1'b0;
      verify_wait <= 1'b0;
`endif
    end else begin
      wr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_write) begin
              WriteData <= req_wdata;
              MemWrite  <= 1'b1;
              state     <= ST_WRITE;
            end else begin
              MemRead <= 1'b1;
              state   <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          // RAM has committed on the negedge inside the strobe cycle
          MemWrite <= 1'b0;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
          MemRead     <= 1'b1;
          verify_wait <= 1'b0;
          state       <= ST_VERIFY;
`else
          wr_done <= 1'b1;
          state   <= ST_IDLE;
`endif
        end
        ST_READ: begin
          if (last) begin
            MemRead <= 1'b0;
            state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave on the edge that presents the final word
          if (issue_sr[0]) begin
            state <= ST_IDLE;
          end
        end
`ifdef MEM_SEQ_WRITE_VERIFY_EN
        ST_VERIFY: begin
          if (!verify_wait) begin
            // RAM sampled the read strobe on this edge; data arrives next cycle
            MemRead     <= 1'b0;
            verify_wait <= 1'b1;
          end else begin
            wr_done <= 1'b1;
            wr_err  <= (MemData != WriteData);
            state   <= ST_IDLE;
          end
        end
`endif
        default: begin
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_seq_master.sv
// tb/tb_mem_seq_master.sv - directed self-checking bench for mem_seq_master with a behavioural word RAM
module tb_mem_seq_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [3:0]  req_len = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        wr_done;
  logic        wr_err;
  logic        busy;
  logic        MemRead;
  logic        MemWrite;
  logic [9:0]  Address;
  logic [15:0] WriteData;
  wire  [15:0] MemData;

  int checks = 0;
  int errors = 0;

  // RAM model: write on negedge, read registered on posedge
  logic [15:0] mem [0:1023];
  logic [15:0] rdq = '0;
  logic        rdv = 1'b0;
  logic        force_zero = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdv <= MemRead;
    if (MemRead) rdq <= mem[Address];
  end

  always @(negedge clk) begin
    if (MemWrite) mem[Address] <= WriteData;
  end

  assign MemData = rdv ? (force_zero ? 16'h0000 : rdq) : 16'hzzzz;

  mem_seq_master dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .wr_done   (wr_done),
    .wr_err    (wr_err),
    .busy      (busy),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .MemData   (MemData)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps after a write has been accepted and checks completion timing
  task automatic write_tail(input logic exp_err);
    req_valid = 1'b0;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
    step();
    chk("wv_a1_memwrite", MemWrite, 0);
    chk("wv_a1_memread", MemRead, 1);
    chk("wv_a1_done", wr_done, 0);
    chk("wv_a1_ready", req_ready, 0);
    step();
    chk("wv_a2_done", wr_done, 0);
    chk("wv_a2_memread", MemRead, 0);
    step();
    chk("wv_a3_done", wr_done, 1);
    chk("wv_a3_err", wr_err, exp_err);
    chk("wv_a3_ready", req_ready, 1);
    chk("wv_a3_rsp_quiet", rsp_valid, 0);
`else
    step();
    chk("wr_a1_done", wr_done, 1);
    chk("wr_a1_memwrite", MemWrite, 0);
    chk("wr_a1_err", wr_err, exp_err);
    chk("wr_a1_ready", req_ready, 1);
`endif
    step();
    chk("wr_done_pulse", wr_done, 0);
  endtask

  task automatic do_write(input logic [9:0] addr, input logic [15:0] data, input logic exp_err);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
    step();
    chk("wr_a_memwrite", MemWrite, 1);
    chk("wr_a_addr", Address, addr);
    chk("wr_a_wdata", WriteData, data);
    chk("wr_a_ready", req_ready, 0);
    chk("wr_a_busy", busy, 1);
    write_tail(exp_err);
  endtask

  // Read burst; k counts edges after the accepting edge A
  task automatic run_read(input logic [9:0] addr, input logic [3:0] len);
    logic [9:0] ia;
    int n;
    n = int'(len);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
    step();
    req_valid = 1'b0;
    for (int k = 0; k <= n + 3; k++) begin
      if (k > 0) step();
      chk("rd_memread", MemRead, (k <= n));
      if (k <= n) begin
        ia = addr + 10'(k);
        chk("rd_addr", Address, ia);
      end
      chk("rd_valid", rsp_valid, (k >= 2 && k <= n + 2));
      if (k >= 2 && k <= n + 2) begin
        ia = addr + 10'(k - 2);
        chk("rd_data", rsp_data, mem[ia]);
      end
      chk("rd_ready", req_ready, (k >= n + 2));
      chk("rd_memwrite_quiet", MemWrite, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;

    // Reset state
    step();
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_memread", MemRead, 0);
    chk("rst_memwrite", MemWrite, 0);
    chk("rst_addr", Address, 0);
    chk("rst_wdata", WriteData, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_wr_err", wr_err, 0);
    reset = 1'b0;
    step();

    // Reset asserted mid-burst
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h010; req_len = 4'd7;
    step();
    req_valid = 1'b0;
    chk("t1_a_memread", MemRead, 1);
    step();
    chk("t1_a1_addr", Address, 10'h011);
    #2 reset = 1'b1;
    #1;
    chk("t1_rst_memread", MemRead, 0);
    chk("t1_rst_memwrite", MemWrite, 0);
    chk("t1_rst_ready", req_ready, 1);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_valid", rsp_valid, 0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_post_valid", rsp_valid, 0);
      chk("t1_post_memread", MemRead, 0);
      chk("t1_post_ready", req_ready, 1);
    end

    // Write 0x1234 @0x005 then single-beat read back
    do_write(10'h005, 16'h1234, 1'b0);
    chk("t2_ram_word", mem[10'h005], 16'h1234);
    run_read(10'h005, 4'd0);
    chk("t2_rsp_data", rsp_data, 16'h1234);

    // Burst across the top of the address space
    mem[10'h3FE] = 16'd1; mem[10'h3FF] = 16'd2; mem[10'h000] = 16'd3; mem[10'h001] = 16'd4;
    run_read(10'h3FE, 4'd3);
    chk("t3_last_word", rsp_data, 16'd4);

    // Request held while busy: ignored until the edge after the last rsp_valid
    mem[10'h200] = 16'h00A1; mem[10'h201] = 16'h00A2;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h200; req_len = 4'd1;
    step();
    req_write = 1'b1; req_addr = 10'h020; req_wdata = 16'h5A5A;
    step();
    chk("t4_k1_ready", req_ready, 0);
    chk("t4_k1_memwrite", MemWrite, 0);
    chk("t4_k1_addr", Address, 10'h201);
    chk("t4_k1_memread", MemRead, 1);
    step();
    chk("t4_k2_ready", req_ready, 0);
    chk("t4_k2_memwrite", MemWrite, 0);
    chk("t4_k2_memread", MemRead, 0);
    chk("t4_k2_valid", rsp_valid, 1);
    chk("t4_k2_data", rsp_data, 16'h00A1);
    step();
    chk("t4_k3_ready", req_ready, 1);
    chk("t4_k3_memwrite", MemWrite, 0);
    chk("t4_k3_addr", Address, 10'h201);
    chk("t4_k3_valid", rsp_valid, 1);
    chk("t4_k3_data", rsp_data, 16'h00A2);
    step();
    chk("t4_k4_memwrite", MemWrite, 1);
    chk("t4_k4_addr", Address, 10'h020);
    chk("t4_k4_wdata", WriteData, 16'h5A5A);
    chk("t4_k4_ready", req_ready, 0);
    write_tail(1'b0);
    chk("t4_ram_word", mem[10'h020], 16'h5A5A);

    // Maximum burst
    for (int i = 0; i < 16; i++) mem[10'h100 + 10'(i)] = 16'hC000 + 16'(i);
    run_read(10'h100, 4'd15);
    chk("t5_last_word", rsp_data, 16'hC00F);

`ifdef MEM_SEQ_WRITE_VERIFY_EN
    // Write-verify: clean compare, then corrupted read-back
    force_zero = 1'b0;
    do_write(10'h040, 16'hBEEF, 1'b0);
    force_zero = 1'b1;
    do_write(10'h041, 16'hBEEF, 1'b1);
    force_zero = 1'b0;
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
